// File: rtl/specialkey_pkg.sv
// Shared PS/2 set-2 scancode constants, decoder state encoding and OSD bit map.
// The OSD side imports the osd_command bit indices from here as well.
package specialkey_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_E1    = 8'hE1;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_AA    = 8'hAA;
  localparam logic [7:0] SC_00    = 8'h00;
  localparam logic [7:0] SC_FF    = 8'hFF;
  localparam logic [7:0] SC_FA    = 8'hFA;
  localparam logic [7:0] SC_FE    = 8'hFE;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_F11   = 8'h78;
  localparam logic [7:0] SC_F12   = 8'h07;
  localparam logic [7:0] SC_SCRLK = 8'h7E;

  // Bytes still to swallow after E1 (E1 14 77 E1 F0 14 F0 77)
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam int OSD_UP    = 0;
  localparam int OSD_DOWN  = 1;
  localparam int OSD_LEFT  = 2;
  localparam int OSD_RIGHT = 3;
  localparam int OSD_ENTER = 4;
  localparam int OSD_ESC   = 5;
  localparam int OSD_F11   = 6;
  localparam int OSD_F12   = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXT    = 3'd1,
    ST_BRK    = 3'd2,
    ST_EXTBRK = 3'd3,
    ST_PAUSE  = 3'd4
  } state_t;

  typedef struct packed {
    logic       hit;
    logic       scr;
    logic [2:0] idx;
  } key_t;

  function automatic key_t key_lookup(input logic ext, input logic [7:0] code);
    key_t k;
    k = '0;
    case ({ext, code})
      {1'b1, SC_UP}:    begin k.hit = 1'b1; k.idx = 3'(OSD_UP);    end
      {1'b1, SC_DOWN}:  begin k.hit = 1'b1; k.idx = 3'(OSD_DOWN);  end
      {1'b1, SC_LEFT}:  begin k.hit = 1'b1; k.idx = 3'(OSD_LEFT);  end
      {1'b1, SC_RIGHT}: begin k.hit = 1'b1; k.idx = 3'(OSD_RIGHT); end
      {1'b0, SC_ENTER},
      {1'b1, SC_ENTER}: begin k.hit = 1'b1; k.idx = 3'(OSD_ENTER); end
      {1'b0, SC_ESC}:   begin k.hit = 1'b1; k.idx = 3'(OSD_ESC);   end
      {1'b0, SC_F11}:   begin k.hit = 1'b1; k.idx = 3'(OSD_F11);   end
      {1'b0, SC_F12}:   begin k.hit = 1'b1; k.idx = 3'(OSD_F12);   end
      {1'b0, SC_SCRLK}: begin k.hit = 1'b1; k.scr = 1'b1;          end
      default:          k = '0;
    endcase
    return k;
  endfunction

  function automatic logic is_clear_byte(input logic [7:0] code);
    return (code == SC_AA) || (code == SC_00) || (code == SC_FF);
  endfunction

  function automatic logic is_ignore_byte(input logic [7:0] code);
    return (code == SC_FA) || (code == SC_FE);
  endfunction

endpackage

// File: rtl/specialkey_decoder_prefix_timeout.sv
// Prefix watchdog: reloads on every accepted byte, counts down on cpu_ce and
// holds at zero; expired stays high while the count is zero.
module prefix_timeout #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic load,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] RELOAD = W'(TIMEOUT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      cnt <= RELOAD;
    end else if (ce && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/specialkey_decoder.sv
// Special-key front end: PS/2 set-2 prefix tracker and held-level key table
// for the keys handled outside the Vector-06C keyboard matrix.
//
// state  | meaning
// IDLE   | no prefix pending; plain bytes are makes
// EXT    | E0 seen; next byte is an extended make
// BRK    | F0 seen; next byte is a break
// EXTBRK | E0 F0 seen; next byte is an extended break
// PAUSE  | E1 seen; swallowing the rest of the Pause sequence
module specialkey_decoder
  import specialkey_pkg::*;
#(
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_ce,
  input  logic [7:0] scancode,
  input  logic       scancode_ready,
  output logic       key_blksbr,
  output logic       key_osd,
  output logic [7:0] osd_command
);

  state_t     state;
  logic [2:0] skip_cnt;
  logic [7:0] osd_held;
  logic       scr_held;
  logic       expired;
  logic       ext_sel;
  logic       brk_sel;
  key_t       key;

  prefix_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .ce      (cpu_ce),
    .load    (scancode_ready),
    .expired (expired)
  );

  always_comb begin
    ext_sel = (state == ST_EXT) || (state == ST_EXTBRK);
    brk_sel = (state == ST_BRK) || (state == ST_EXTBRK);
    key     = key_lookup(ext_sel, scancode);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
      osd_held <= '0;
      scr_held <= 1'b0;
    end else if (scancode_ready) begin
      if (state == ST_PAUSE) begin
        // Every byte inside Pause is swallowed, special bytes included
        if (skip_cnt <= 3'd1) begin
          skip_cnt <= '0;
          state    <= ST_IDLE;
        end else begin
          skip_cnt <= skip_cnt - 3'd1;
        end
      end else if (is_clear_byte(scancode)) begin
        osd_held <= '0;
        scr_held <= 1'b0;
        state    <= ST_IDLE;
      end else if (is_ignore_byte(scancode)) begin
        state <= state;
      end else if (scancode == SC_E1) begin
        state    <= ST_PAUSE;
        skip_cnt <= PAUSE_SKIP;
      end else if (scancode == SC_E0) begin
        state <= ST_EXT;
      end else if (scancode == SC_F0) begin
        state <= ext_sel ? ST_EXTBRK : ST_BRK;
      end else begin
        if (key.hit) begin
          if (key.scr) begin
            scr_held <= ~brk_sel;
          end else begin
            osd_held[key.idx] <= ~brk_sel;
          end
        end
        state <= ST_IDLE;
      end
    end else if (expired && (state != ST_IDLE)) begin
      // Stale prefix is dropped; held keys are left alone
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end
  end

  assign osd_command = osd_held;
  assign key_blksbr  = osd_held[OSD_F12];
  assign key_osd     = scr_held;

endmodule

// File: tb/tb_specialkey_decoder.sv
// Scoreboard bench for specialkey_decoder: directed scenarios followed by
// random key/Pause/special-byte events checked against a key-set model.
module tb_specialkey_decoder;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_ce;
  logic [7:0] scancode;
  logic       scancode_ready;
  logic       key_blksbr;
  logic       key_osd;
  logic [7:0] osd_command;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic [8:0] m_exp;
  logic       strobe_d = 1'b0;
  logic       ce_rand = 1'b0;

  logic [7:0] key_code [14] = '{8'h07, 8'h7E, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A,
                                8'h5A, 8'h76, 8'h78, 8'h12, 8'h59, 8'h75, 8'h1C};
  logic       key_ext  [14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
  logic [7:0] clr_bytes [3] = '{8'hAA, 8'h00, 8'hFF};

  specialkey_decoder #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_ce         (cpu_ce),
    .scancode       (scancode),
    .scancode_ready (scancode_ready),
    .key_blksbr     (key_blksbr),
    .key_osd        (key_osd),
    .osd_command    (osd_command)
  );

  always #5 clk = ~clk;

  // Bit affected by a key: 0..7 osd_command, 8 ScrollLock, -1 none
  function automatic int key_effect(input logic ext, input logic [7:0] code);
    if (ext) begin
      case (code)
        8'h75: return 0;
        8'h72: return 1;
        8'h6B: return 2;
        8'h74: return 3;
        8'h5A: return 4;
        default: return -1;
      endcase
    end
    case (code)
      8'h5A: return 4;
      8'h76: return 5;
      8'h78: return 6;
      8'h07: return 7;
      8'h7E: return 8;
      default: return -1;
    endcase
  endfunction

  task automatic send(input logic [7:0] b, input logic [8:0] e);
    scancode       = b;
    scancode_ready = 1'b1;
    cpu_ce         = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    scancode_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      cpu_ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    cpu_ce = 1'b0;
  endtask

  task automatic ticks(input int n);
    cpu_ce = 1'b1;
    repeat (n) @(negedge clk);
    cpu_ce = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) strobe_d <= scancode_ready && !reset;

  always @(negedge clk) begin
    logic [8:0] e;
    if (strobe_d) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: output event with empty expectation queue");
      end else begin
        e = exp_q.pop_front();
        if ({key_osd, osd_command} !== e || key_blksbr !== e[7]) begin
          errors++;
          $display("FAIL outputs @%0t: got osd=%02h scr=%0b blksbr=%0b, want osd=%02h scr=%0b blksbr=%0b",
                   $time, osd_command, key_osd, key_blksbr, e[7:0], e[8], e[7]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    cpu_ce         = 1'b0;
    scancode       = 8'h00;
    scancode_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_osd", 32'(osd_command), 32'h00);
    check("reset_keys", {30'd0, key_osd, key_blksbr}, 32'h0);
    reset = 1'b0;
    idle(2);

    // F12 make/break
    send(8'h07, 9'h080); send(8'hF0, 9'h080); send(8'h07, 9'h000);
    // extended arrows, back-to-back bytes
    send(8'hE0, 9'h000); send(8'h75, 9'h001);
    send(8'hE0, 9'h001); send(8'h6B, 9'h005);
    send(8'hE0, 9'h005); send(8'hF0, 9'h005); send(8'h75, 9'h004);
    send(8'hE0, 9'h004); send(8'hF0, 9'h004); send(8'h6B, 9'h000);
    idle(2);
    // Pause swallowed, then ScrollLock
    foreach (pause_seq[i]) send(pause_seq[i], 9'h000);
    send(8'h7E, 9'h100); send(8'hF0, 9'h100); send(8'h7E, 9'h000);
    // Pause count covers exactly seven bytes, special bytes included
    send(8'hE1, 9'h000); send(8'h76, 9'h000); send(8'hAA, 9'h000);
    repeat (5) send(8'h76, 9'h000);
    send(8'h78, 9'h040); send(8'hF0, 9'h040); send(8'h78, 9'h000);
    idle(2);
    // clear bytes drop held keys and the pending prefix
    foreach (clr_bytes[i]) begin
      send(8'h78, 9'h040); send(8'h76, 9'h060);
      send(8'hE0, 9'h060); send(clr_bytes[i], 9'h000);
      send(8'h75, 9'h000);
      idle(1);
    end
    // FA/FE ignored without disturbing the prefix; repeated prefix
    send(8'hE0, 9'h000); send(8'hFA, 9'h000); send(8'h75, 9'h001);
    send(8'h75, 9'h000 | 9'h001);
    send(8'hE0, 9'h001); send(8'hE0, 9'h001); send(8'h72, 9'h003);
    send(8'hE0, 9'h003); send(8'hFE, 9'h003); send(8'hF0, 9'h003); send(8'h72, 9'h001);
    send(8'hE0, 9'h001); send(8'hF0, 9'h001); send(8'h75, 9'h000);
    send(8'hE0, 9'h000); send(8'h12, 9'h000); send(8'hE0, 9'h000); send(8'h59, 9'h000);
    idle(2);
    // timeout: prefix dropped one cycle after expiry, held keys kept
    send(8'h78, 9'h040);
    send(8'hE0, 9'h040); ticks(TO); idle(1); send(8'h75, 9'h040);
    send(8'hF0, 9'h040); send(8'h78, 9'h000);
    // byte landing in the expiry cycle wins
    send(8'hE0, 9'h000); ticks(TO); send(8'h75, 9'h001);
    send(8'hE0, 9'h001); ticks(TO - 1); send(8'hF0, 9'h001); send(8'h75, 9'h000);
    idle(2);
    // reset mid-sequence
    send(8'h76, 9'h020); send(8'hE0, 9'h020); send(8'hF0, 9'h020);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_osd", 32'(osd_command), 32'h00);
    check("midreset_keys", {30'd0, key_osd, key_blksbr}, 32'h0);
    reset = 1'b0;
    send(8'h5A, 9'h010); send(8'hF0, 9'h010); send(8'h5A, 9'h000);
    idle(3);

    // random events against the key-set model
    m_exp   = 9'h000;
    ce_rand = 1'b1;
    for (int ev = 0; ev < 300; ev++) begin
      int         r;
      int         k;
      int         eff;
      logic       brk;
      logic [8:0] nxt;
      r = $urandom_range(0, 99);
      if (r < 70) begin
        k   = $urandom_range(0, 13);
        brk = 1'($urandom_range(0, 1));
        eff = key_effect(key_ext[k], key_code[k]);
        nxt = m_exp;
        if (eff >= 0) nxt[eff] = ~brk;
        if (key_ext[k]) begin send(8'hE0, m_exp); idle($urandom_range(0, 2)); end
        if (brk) begin send(8'hF0, m_exp); idle($urandom_range(0, 2)); end
        send(key_code[k], nxt);
        m_exp = nxt;
      end else if (r < 78) begin
        foreach (pause_seq[i]) begin
          send(pause_seq[i], m_exp);
          idle($urandom_range(0, 1));
        end
      end else if (r < 86) begin
        m_exp = 9'h000;
        send(clr_bytes[$urandom_range(0, 2)], m_exp);
      end else begin
        send(($urandom_range(0, 1) != 0) ? 8'hFA : 8'hFE, m_exp);
      end
      idle($urandom_range(0, 4));
    end
    ce_rand = 1'b0;
    idle(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
